// File: rtl/ui_io_pkg.sv
// ui_io_pkg
//   Shared definitions for the TT user-input SPI receive path.
//   - Pin index constants for the SPI signals on ui_in.
//   - Idle pin levels used as synchroniser reset values.
//   - Status byte layout returned to the host on MISO.
//   - Default synchroniser depth.
package ui_io_pkg;

    // Bit positions of the SPI signals within ui_in
    localparam int unsigned PIN_SCLK = 0;
    localparam int unsigned PIN_CS_N = 1;
    localparam int unsigned PIN_MOSI = 2;

    // Idle levels of the SPI pins (mode 0, deselected)
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_N_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // Status byte, MSB shifted out first
    typedef struct packed {
        logic       ovf;    // [7]   sticky receive overflow
        logic [3:0] level;  // [6:3] FIFO occupancy
        logic [2:0] pad;    // [2:0] always zero
    } status_t;

    function automatic logic [7:0] make_status(input logic ovf, input logic [3:0] level);
        status_t s;
        s.ovf   = ovf;
        s.level = level;
        s.pad   = '0;
        return s;
    endfunction

endpackage

// File: rtl/ui_pin_sync.sv
// ui_pin_sync
//   STAGES-deep flip-flop synchroniser for one asynchronous input pin, with
//   single-cycle rise/fall pulses derived from the last two synchronised samples.
// Ports
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset; all flops load RST_VAL
//   pin    in   asynchronous pin
//   sync   out  synchronised pin level
//   rise   out  one-cycle pulse on a synchronised 0->1 transition
//   fall   out  one-cycle pulse on a synchronised 1->0 transition
module ui_pin_sync
    import ui_io_pkg::*;
#(
    parameter int unsigned STAGES  = DEFAULT_SYNC_STAGES,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/ui_spi_byte_rx.sv
// ui_spi_byte_rx
//   SPI mode 0 byte receiver on the dedicated input pins. Received bytes are
//   queued in a FIFO_DEPTH-entry FIFO and handed to the core over valid/ready.
//   A status byte {overflow, level, 3'b000} is returned to the host on MISO,
//   latched at the start of each chip-select frame.
// Ports
//   clk          in   system clock (only clock)
//   rst_n        in   synchronous active-low reset
//   spi_sclk     in   host SPI clock, asynchronous
//   spi_cs_n     in   host chip select, active-low
//   spi_mosi     in   host data, MSB first
//   spi_miso     out  status bit to host, 0 while deselected
//   rx_data      out  FIFO head byte (0 when empty)
//   rx_valid     out  FIFO not empty
//   rx_ready     in   consumer pops head when rx_valid && rx_ready
//   rx_overflow  out  sticky: a complete byte was dropped on a full FIFO
//   ovf_clear    in   clears rx_overflow (a same-cycle set wins)
//   fifo_level   out  FIFO occupancy 0..FIFO_DEPTH
module ui_spi_byte_rx
    import ui_io_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overflow,
    input  logic       ovf_clear,
    output logic [3:0] fifo_level
);

    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  LEVEL_FULL = 4'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Pin synchronisation
    // ------------------------------------------------------------------
    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    ui_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (spi_sclk),
        .sync (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    ui_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_N_IDLE)) u_sync_cs_n (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (spi_cs_n),
        .sync (cs_n_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) mosi_chain <= {SYNC_STAGES{MOSI_IDLE}};
        else        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Framing: shift on sclk rise while selected; a rise coinciding with
    // the synchronised cs_n fall is ignored.
    // ------------------------------------------------------------------
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic       push_pend;
    logic       shift_en;

    assign shift_en = sclk_rise & sclk_s & ~cs_n_s & ~cs_fall;

    // shreg is not cleared on deselect: bitcnt alone decides completeness,
    // and shreg still holds the finished byte during the push cycle because
    // the next rise is at least four clk away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitcnt    <= '0;
            shreg     <= '0;
            push_pend <= 1'b0;
        end else begin
            push_pend <= 1'b0;
            if (cs_n_s) begin
                bitcnt <= '0;
            end else if (shift_en) begin
                shreg     <= {shreg[6:0], mosi_s};
                bitcnt    <= bitcnt + 3'd1;
                push_pend <= (bitcnt == 3'd7);
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [3:0]       level;
    logic             ovf_q;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;
    logic             ovf_set;

    assign fifo_full = (level == LEVEL_FULL);
    assign do_pop    = rx_valid & rx_ready;
    assign do_push   = push_pend & (~fifo_full | do_pop);
    assign ovf_set   = push_pend & fifo_full & ~do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + 4'd1;
                2'b01:   level <= level - 4'd1;
                default: level <= level;
            endcase
            if (ovf_set)        ovf_q <= 1'b1;
            else if (ovf_clear) ovf_q <= 1'b0;
        end
    end

    assign rx_valid    = (level != 4'd0);
    assign rx_data     = rx_valid ? mem[rd_ptr] : '0;
    assign rx_overflow = ovf_q;
    assign fifo_level  = level;

    // ------------------------------------------------------------------
    // MISO status shifter
    // ------------------------------------------------------------------
    logic [7:0] status_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q <= '0;
        end else if (cs_fall) begin
            status_q <= make_status(ovf_q, level);
        end else if (cs_rise) begin
            status_q <= '0;
        end else if (sclk_fall && !cs_n_s) begin
            status_q <= {status_q[6:0], 1'b0};
        end
    end

    assign spi_miso = status_q[7] & ~cs_n_s;

endmodule
